// File: rtl/acc_seq_ctrl.sv
// rtl/acc_seq_ctrl.sv - tap/sub-cycle/neuron sequencer for a neuron MAC accumulator
//
// Purpose: walks NUM_TAPS taps, holding each for SUB_CYCLES clocks, across
// NUM_NEURONS neurons per pass. It flags the bias tap (sel) and the final tap (en),
// strobes step on the last sub-cycle of every tap, and offers a start/done handshake,
// stall, abort and free-run looping.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   start      in   1      begin a pass (sampled only in IDLE)
//   free_run   in   1      loop passes forever (latched at start)
//   stall      in   1      freeze all counters this cycle
//   abort      in   1      synchronous return to IDLE, no done
//   sel        out  1      tap_idx==0 while running (bias add)
//   en         out  1      tap_idx==NUM_TAPS-1 while running (finish accumulation)
//   step       out  1      last sub-cycle of a tap, unstalled
//   tap_idx    out  TAP_W  current tap
//   neuron_idx out  NRN_W  current neuron
//   busy       out  1      high in RUN
//   done       out  1      one-cycle pulse after the final tap of a non-free-run pass
module acc_seq_ctrl #(
  parameter int NUM_TAPS    = 16,
  parameter int SUB_CYCLES  = 3,
  parameter int NUM_NEURONS = 1,
  parameter int TAP_W       = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1,
  parameter int NRN_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             free_run,
  input  logic             stall,
  input  logic             abort,
  output logic             sel,
  output logic             en,
  output logic             step,
  output logic [TAP_W-1:0] tap_idx,
  output logic [NRN_W-1:0] neuron_idx,
  output logic             busy,
  output logic             done
);

  localparam int SUB_W = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);
  localparam logic [NRN_W-1:0] NRN_LAST = NRN_W'(NUM_NEURONS - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_CYCLES - 1);

  logic [0:0]       state;
  logic [SUB_W-1:0] sub_cnt;
  logic             free_run_q;
  logic             done_q;
  logic             run;
  logic             last_sub;
  logic             last_tap;
  logic             last_nrn;

  assign run      = (state == ST_RUN);
  assign last_sub = (sub_cnt == SUB_LAST);
  assign last_tap = (tap_idx == TAP_LAST);
  assign last_nrn = (neuron_idx == NRN_LAST);

  // Counters are always returned to zero on the way into IDLE, so IDLE needs no
  // separate clearing and entering RUN starts from tap 0 / sub 0 / neuron 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sub_cnt    <= '0;
      tap_idx    <= '0;
      neuron_idx <= '0;
      free_run_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // Abort wins over start, stall and sequencing; no done is raised.
        state      <= ST_IDLE;
        sub_cnt    <= '0;
        tap_idx    <= '0;
        neuron_idx <= '0;
        free_run_q <= 1'b0;
      end else if (state == ST_IDLE) begin
        if (start) begin
          state      <= ST_RUN;
          sub_cnt    <= '0;
          tap_idx    <= '0;
          neuron_idx <= '0;
          free_run_q <= free_run;
        end
      end else if (!stall) begin
        if (last_sub) begin
          sub_cnt <= '0;
          if (last_tap) begin
            tap_idx <= '0;
            if (last_nrn) begin
              neuron_idx <= '0;
              if (!free_run_q) begin
                state  <= ST_IDLE;
                done_q <= 1'b1;
              end
            end else begin
              neuron_idx <= neuron_idx + NRN_W'(1);
            end
          end else begin
            tap_idx <= tap_idx + TAP_W'(1);
          end
        end else begin
          sub_cnt <= sub_cnt + SUB_W'(1);
        end
      end
    end
  end

  // Decoded outputs follow the (possibly frozen) indices with no added latency.
  assign busy = run;
  assign sel  = run && (tap_idx == '0);
  assign en   = run && last_tap;
  assign step = run && !stall && last_sub;
  assign done = done_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb/tb_acc_seq_ctrl.sv - scoreboard bench for acc_seq_ctrl
module tb_acc_seq_ctrl;

  typedef struct {
    int   cyc;
    int   tap;
    int   nrn;
    logic sel;
    logic en;
    logic step;
    logic done;
    logic busy;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   busy_cnt_a;
  int   busy_cnt_b;

  ev_t q_a[$];
  ev_t q_b[$];

  // DUT A: defaults 16 taps x 3 sub-cycles x 1 neuron
  logic       start_a, free_run_a, stall_a, abort_a;
  logic       sel_a, en_a, step_a, busy_a, done_a;
  logic [3:0] tap_a;
  logic [0:0] nrn_a;

  // DUT B: 4 taps x 1 sub-cycle x 4 neurons
  logic       start_b, free_run_b, stall_b, abort_b;
  logic       sel_b, en_b, step_b, busy_b, done_b;
  logic [1:0] tap_b;
  logic [1:0] nrn_b;

  acc_seq_ctrl u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .free_run(free_run_a),
    .stall(stall_a), .abort(abort_a), .sel(sel_a), .en(en_a), .step(step_a),
    .tap_idx(tap_a), .neuron_idx(nrn_a), .busy(busy_a), .done(done_a)
  );

  acc_seq_ctrl #(.NUM_TAPS(4), .SUB_CYCLES(1), .NUM_NEURONS(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .free_run(free_run_b),
    .stall(stall_b), .abort(abort_b), .sel(sel_b), .en(en_b), .step(step_b),
    .tap_idx(tap_b), .neuron_idx(nrn_b), .busy(busy_b), .done(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(int c, int tap, int nrn, logic s, logic e,
                             logic st, logic d, logic b);
    ev_t r;
    r.cyc = c; r.tap = tap; r.nrn = nrn; r.sel = s; r.en = e;
    r.step = st; r.done = d; r.busy = b;
    return r;
  endfunction

  function automatic bit ev_diff(ev_t x, ev_t y);
    return (x.cyc !== y.cyc) || (x.tap !== y.tap) || (x.nrn !== y.nrn) ||
           (x.sel !== y.sel) || (x.en !== y.en) || (x.step !== y.step) ||
           (x.done !== y.done) || (x.busy !== y.busy);
  endfunction

  task automatic report(string name, ev_t act, ev_t exp);
    $display("FAIL %s: got cyc=%0d tap=%0d nrn=%0d sel=%b en=%b step=%b done=%b busy=%b, want cyc=%0d tap=%0d nrn=%0d sel=%b en=%b step=%b done=%b busy=%b",
             name, act.cyc, act.tap, act.nrn, act.sel, act.en, act.step, act.done, act.busy,
             exp.cyc, exp.tap, exp.nrn, exp.sel, exp.en, exp.step, exp.done, exp.busy);
  endtask

  // Monitor: whenever a DUT strobes step or done, pop and compare the expected event.
  always @(negedge clk) begin
    ev_t act;
    ev_t exp;
    if (busy_a) busy_cnt_a++;
    if (busy_b) busy_cnt_b++;
    if (step_a || done_a) begin
      act = mk(cyc, int'(tap_a), int'(nrn_a), sel_a, en_a, step_a, done_a, busy_a);
      vectors++;
      if (q_a.size() == 0) begin
        miscompares++;
        report("ev_a_unexpected", act, mk(-1, 0, 0, 0, 0, 0, 0, 0));
      end else begin
        exp = q_a.pop_front();
        if (ev_diff(act, exp)) begin
          miscompares++;
          report("ev_a", act, exp);
        end
      end
    end
    if (step_b || done_b) begin
      act = mk(cyc, int'(tap_b), int'(nrn_b), sel_b, en_b, step_b, done_b, busy_b);
      vectors++;
      if (q_b.size() == 0) begin
        miscompares++;
        report("ev_b_unexpected", act, mk(-1, 0, 0, 0, 0, 0, 0, 0));
      end else begin
        exp = q_b.pop_front();
        if (ev_diff(act, exp)) begin
          miscompares++;
          report("ev_b", act, exp);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse_a(logic fr, output int t0);
    @(posedge clk);
    #1;
    start_a    = 1'b1;
    free_run_a = fr;
    t0         = cyc;
    @(posedge clk);
    #1;
    start_a    = 1'b0;
    free_run_a = 1'b0;
  endtask

  // Full default pass without stall: step at RUN cycle 3k+3 for tap k, done one cycle after cycle 48.
  task automatic push_pass_a(int t0);
    for (int k = 0; k < 16; k++)
      q_a.push_back(mk(t0 + 3*k + 3, k, 0, k == 0, k == 15, 1'b1, 1'b0, 1'b1));
    q_a.push_back(mk(t0 + 49, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
  endtask

  initial begin
    int t0;
    vectors = 0; miscompares = 0; busy_cnt_a = 0; busy_cnt_b = 0;
    rst = 1'b1;
    start_a = 0; free_run_a = 0; stall_a = 0; abort_a = 0;
    start_b = 0; free_run_b = 0; stall_b = 0; abort_b = 0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    chk("rst_busy_a", busy_a, 0);
    chk("rst_sel_a",  sel_a, 0);
    chk("rst_en_a",   en_a, 0);
    chk("rst_step_a", step_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_tap_a",  tap_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_nrn_b",  nrn_b, 0);

    // 1: single default pass
    busy_cnt_a = 0;
    start_pulse_a(1'b0, t0);
    push_pass_a(t0);
    tick(52);
    chk("t1_busy_cycles", busy_cnt_a, 48);
    chk("t1_drain", q_a.size(), 0);
    chk("t1_idle", busy_a, 0);

    // 2: 4 taps x 1 sub x 4 neurons on DUT B
    busy_cnt_b = 0;
    @(posedge clk);
    #1;
    start_b = 1'b1;
    t0 = cyc;
    for (int c = 1; c <= 16; c++)
      q_b.push_back(mk(t0 + c, (c-1) % 4, (c-1) / 4, ((c-1) % 4) == 0,
                       ((c-1) % 4) == 3, 1'b1, 1'b0, 1'b1));
    q_b.push_back(mk(t0 + 17, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(1);
    start_b = 1'b0;
    tick(20);
    chk("t2_busy_cycles", busy_cnt_b, 16);
    chk("t2_drain", q_b.size(), 0);

    // 3: free-run wraps with sel re-asserted and never signals done
    start_pulse_a(1'b1, t0);
    for (int j = 1; j <= 66; j++)
      q_a.push_back(mk(t0 + 3*j, (j-1) % 16, 0, ((j-1) % 16) == 0,
                       ((j-1) % 16) == 15, 1'b1, 1'b0, 1'b1));
    tick(197);
    chk("t3_still_busy", busy_a, 1);
    abort_a = 1'b1;
    tick(1);
    abort_a = 1'b0;
    chk("t3_abort_idle", busy_a, 0);
    tick(5);
    chk("t3_drain", q_a.size(), 0);

    // 4: stall held 5 cycles in the middle of tap 7
    busy_cnt_a = 0;
    start_pulse_a(1'b0, t0);
    for (int k = 0; k < 16; k++)
      q_a.push_back(mk(t0 + 3*k + 3 + ((k >= 7) ? 5 : 0), k, 0, k == 0, k == 15,
                       1'b1, 1'b0, 1'b1));
    q_a.push_back(mk(t0 + 54, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(22);
    stall_a = 1'b1;
    tick(2);
    chk("t4_stall_tap", tap_a, 7);
    chk("t4_stall_step", step_a, 0);
    tick(3);
    stall_a = 1'b0;
    tick(30);
    chk("t4_busy_cycles", busy_cnt_a, 53);
    chk("t4_drain", q_a.size(), 0);

    // 5: abort at tap 9 together with start; done must never pulse
    start_pulse_a(1'b0, t0);
    for (int k = 0; k < 9; k++)
      q_a.push_back(mk(t0 + 3*k + 3, k, 0, k == 0, 1'b0, 1'b1, 1'b0, 1'b1));
    tick(27);
    chk("t5_tap9", tap_a, 9);
    abort_a = 1'b1;
    start_a = 1'b1;
    tick(1);
    chk("t5_abort_busy", busy_a, 0);
    chk("t5_abort_tap", tap_a, 0);
    tick(1);
    chk("t5_abort_start_idle", busy_a, 0);
    abort_a = 1'b0;
    start_a = 1'b0;
    tick(25);
    chk("t5_no_done_drain", q_a.size(), 0);

    // 6: rst mid-run with start held high
    @(posedge clk);
    #1;
    start_a = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 3; k++)
      q_a.push_back(mk(t0 + 3*k + 3, k, 0, k == 0, 1'b0, 1'b1, 1'b0, 1'b1));
    tick(10);
    chk("t6_pre_busy", busy_a, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy_a, 0);
    chk("t6_rst_tap", tap_a, 0);
    chk("t6_rst_sel", sel_a, 0);
    chk("t6_rst_step", step_a, 0);
    chk("t6_rst_done", done_a, 0);
    tick(2);
    start_a = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(4);
    chk("t6_no_restart", busy_a, 0);
    chk("t6_drain_a", q_a.size(), 0);
    start_pulse_a(1'b0, t0);
    push_pass_a(t0);
    tick(52);
    chk("t6_restart_drain", q_a.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
